// File: rtl/demux_pkg.sv
// Shared definitions for the 1:6 demux and its 6:1 mux counterpart.
// decode_dest is the single source of truth for destination-code folding.
package demux_pkg;

   localparam int NUM_LANES = 6;
   localparam int DEST_W    = 3;

   typedef logic [DEST_W-1:0] lane_idx_t;

   // Codes 5, 6 and 7 all land on the last lane, matching the mux select.
   function automatic lane_idx_t decode_dest(input logic [DEST_W-1:0] dest);
      return (dest >= lane_idx_t'(NUM_LANES - 1)) ? lane_idx_t'(NUM_LANES - 1) : dest;
   endfunction

endpackage

// File: rtl/demux_lane.sv
// Single-entry holding register with valid/ready; a write in the same cycle
// as a drain keeps the lane full so each lane sustains one item per cycle.
module demux_lane #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_ready,
   output logic [WIDTH-1:0] data,
   output logic             valid
);

   // Data is deliberately left in place on drain; only reset clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data  <= '0;
         valid <= 1'b0;
      end else if (wr_en) begin
         data  <= wr_data;
         valid <= 1'b1;
      end else if (rd_ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/demux_1x6.sv
// 1:6 registered demultiplexer: decodes the destination, steers accepted
// items into per-lane holding registers and counts acceptances.
module demux_1x6
   import demux_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WIDTH-1:0]     in_data,
   input  logic [DEST_W-1:0]    in_dest,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [WIDTH-1:0]     out_0,
   output logic [WIDTH-1:0]     out_1,
   output logic [WIDTH-1:0]     out_2,
   output logic [WIDTH-1:0]     out_3,
   output logic [WIDTH-1:0]     out_4,
   output logic [WIDTH-1:0]     out_5,
   output logic [NUM_LANES-1:0] out_valid,
   input  logic [NUM_LANES-1:0] out_ready,
   output logic [CNT_W-1:0]     acc_count
);

   lane_idx_t                        dest_lane;
   logic                             accept;
   logic [NUM_LANES-1:0][WIDTH-1:0] lane_data;

   assign dest_lane = decode_dest(in_dest);

   // out_ready feeds in_ready combinationally so a full lane can drain and
   // refill in the same cycle.
   assign in_ready = !out_valid[dest_lane] || out_ready[dest_lane];
   assign accept   = in_valid && in_ready;

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      demux_lane #(.WIDTH(WIDTH)) u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .wr_en    (accept && (dest_lane == lane_idx_t'(k))),
         .wr_data  (in_data),
         .rd_ready (out_ready[k]),
         .data     (lane_data[k]),
         .valid    (out_valid[k])
      );
   end

   assign out_0 = lane_data[0];
   assign out_1 = lane_data[1];
   assign out_2 = lane_data[2];
   assign out_3 = lane_data[3];
   assign out_4 = lane_data[4];
   assign out_5 = lane_data[5];

   // Saturating counter: sticks at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         acc_count <= '0;
      else if (accept && !(&acc_count))
         acc_count <= acc_count + CNT_W'(1);
   end

endmodule

// File: tb/tb_demux_1x6.sv
// Directed vector bench for demux_1x6: table-driven routing/handshake vectors
// followed by hand-written saturation and asynchronous-reset sequences.
module tb_demux_1x6;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  in_data;
   logic [2:0]  in_dest;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  out_0, out_1, out_2, out_3, out_4, out_5;
   logic [5:0]  out_valid;
   logic [5:0]  out_ready;
   logic [15:0] acc_count;
   logic [7:0]  lanes [6];

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   demux_1x6 #(.WIDTH(8), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_dest(in_dest),
      .in_valid(in_valid), .in_ready(in_ready),
      .out_0(out_0), .out_1(out_1), .out_2(out_2), .out_3(out_3),
      .out_4(out_4), .out_5(out_5), .out_valid(out_valid),
      .out_ready(out_ready), .acc_count(acc_count)
   );

   assign lanes[0] = out_0;
   assign lanes[1] = out_1;
   assign lanes[2] = out_2;
   assign lanes[3] = out_3;
   assign lanes[4] = out_4;
   assign lanes[5] = out_5;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Producer rule: a stalled item must be re-offered unchanged.
   logic       stalled = 1'b0;
   logic [7:0] held_data;
   logic [2:0] held_dest;
   always @(posedge clk) begin
      if (rst_n && stalled && in_valid)
         chk("producer_stable", {21'd0, in_dest, in_data}, {21'd0, held_dest, held_data});
      stalled   = rst_n && in_valid && !in_ready;
      held_data = in_data;
      held_dest = in_dest;
   end

   typedef struct {
      logic        vld;
      logic [2:0]  dest;
      logic [7:0]  data;
      logic [5:0]  rdy;
      logic        exp_rdy;
      logic [5:0]  exp_ov;
      logic [15:0] exp_cnt;
      int          lane;
      logic [7:0]  exp_data;
   } vec_t;

   function automatic vec_t mk(logic vld, logic [2:0] dest, logic [7:0] data, logic [5:0] rdy,
                               logic exp_rdy, logic [5:0] exp_ov, logic [15:0] exp_cnt,
                               int lane, logic [7:0] exp_data);
      vec_t v;
      v.vld = vld; v.dest = dest; v.data = data; v.rdy = rdy;
      v.exp_rdy = exp_rdy; v.exp_ov = exp_ov; v.exp_cnt = exp_cnt;
      v.lane = lane; v.exp_data = exp_data;
      return v;
   endfunction

   vec_t vecs[16];

   initial begin
      // first accept, stall on full lane, drain+refill
      vecs[0]  = mk(1, 3'd3, 8'hA5, 6'b000000, 1, 6'b001000, 16'd1,  3, 8'hA5);
      vecs[1]  = mk(1, 3'd2, 8'h11, 6'b000000, 1, 6'b001100, 16'd2,  2, 8'h11);
      vecs[2]  = mk(1, 3'd2, 8'h22, 6'b000000, 0, 6'b001100, 16'd2,  2, 8'h11);
      vecs[3]  = mk(1, 3'd2, 8'h22, 6'b000100, 1, 6'b001100, 16'd3,  2, 8'h22);
      vecs[4]  = mk(0, 3'd0, 8'hEE, 6'b001101, 1, 6'b000000, 16'd3,  2, 8'h22);
      // dest fold 5/6/7 onto lane 5
      vecs[5]  = mk(1, 3'd5, 8'h50, 6'b100000, 1, 6'b100000, 16'd4,  5, 8'h50);
      vecs[6]  = mk(1, 3'd6, 8'h61, 6'b100000, 1, 6'b100000, 16'd5,  5, 8'h61);
      vecs[7]  = mk(1, 3'd7, 8'h72, 6'b100000, 1, 6'b100000, 16'd6,  5, 8'h72);
      vecs[8]  = mk(0, 3'd0, 8'h00, 6'b100000, 1, 6'b000000, 16'd6,  5, 8'h72);
      // back-to-back stream across all lanes
      vecs[9]  = mk(1, 3'd0, 8'h20, 6'b111111, 1, 6'b000001, 16'd7,  0, 8'h20);
      vecs[10] = mk(1, 3'd1, 8'h21, 6'b111111, 1, 6'b000010, 16'd8,  1, 8'h21);
      vecs[11] = mk(1, 3'd2, 8'h22, 6'b111111, 1, 6'b000100, 16'd9,  2, 8'h22);
      vecs[12] = mk(1, 3'd3, 8'h23, 6'b111111, 1, 6'b001000, 16'd10, 3, 8'h23);
      vecs[13] = mk(1, 3'd4, 8'h24, 6'b111111, 1, 6'b010000, 16'd11, 4, 8'h24);
      vecs[14] = mk(1, 3'd5, 8'h25, 6'b111111, 1, 6'b100000, 16'd12, 5, 8'h25);
      vecs[15] = mk(0, 3'd0, 8'h00, 6'b111111, 1, 6'b000000, 16'd12, 0, 8'h20);

      rst_n = 1'b0; in_valid = 1'b0; in_dest = '0; in_data = '0; out_ready = '0;
      #1;
      chk("reset_out_valid", {26'd0, out_valid}, 32'd0);
      chk("reset_acc_count", {16'd0, acc_count}, 32'd0);
      chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
      for (int k = 0; k < 6; k++)
         chk($sformatf("reset_out_%0d", k), {24'd0, lanes[k]}, 32'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 16; i++) begin
         in_valid = vecs[i].vld; in_dest = vecs[i].dest;
         in_data = vecs[i].data; out_ready = vecs[i].rdy;
         #1;
         chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].exp_rdy});
         @(posedge clk); #1;
         chk($sformatf("v%0d_out_valid", i), {26'd0, out_valid}, {26'd0, vecs[i].exp_ov});
         chk($sformatf("v%0d_acc_count", i), {16'd0, acc_count}, {16'd0, vecs[i].exp_cnt});
         chk($sformatf("v%0d_out_%0d", i, vecs[i].lane), {24'd0, lanes[vecs[i].lane]},
             {24'd0, vecs[i].exp_data});
         if (i == 0)
            for (int k = 0; k < 6; k++)
               if (k != 3) chk($sformatf("v0_out_%0d_zero", k), {24'd0, lanes[k]}, 32'd0);
         @(negedge clk);
      end

      // Saturation: continuous accepts up to 16'hFFFE, then three more.
      in_valid = 1'b1; in_dest = 3'd0; in_data = 8'h33; out_ready = 6'b111111;
      repeat (65534 - 12) @(posedge clk);
      #1;
      chk("sat_fffe", {16'd0, acc_count}, 32'h0000FFFE);
      repeat (3) @(posedge clk);
      #1;
      chk("sat_ffff", {16'd0, acc_count}, 32'h0000FFFF);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      chk("drained", {26'd0, out_valid}, 32'd0);

      // Fill lanes 0 and 4, then assert reset between clock edges.
      in_valid = 1'b1; in_dest = 3'd0; in_data = 8'h0A; out_ready = '0;
      @(negedge clk);
      in_dest = 3'd4; in_data = 8'h4B;
      @(negedge clk);
      in_valid = 1'b0;
      chk("prerst_out_valid", {26'd0, out_valid}, 32'b010001);
      chk("prerst_out_4", {24'd0, out_4}, 32'h4B);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", {26'd0, out_valid}, 32'd0);
      chk("async_rst_out_0", {24'd0, out_0}, 32'd0);
      chk("async_rst_out_4", {24'd0, out_4}, 32'd0);
      chk("async_rst_acc_count", {16'd0, acc_count}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      in_valid = 1'b1; in_dest = 3'd1; in_data = 8'h77;
      @(posedge clk); #1;
      chk("post_rst_acc_count", {16'd0, acc_count}, 32'd1);
      chk("post_rst_out_valid", {26'd0, out_valid}, 32'b000010);
      chk("post_rst_out_1", {24'd0, out_1}, 32'h77);
      @(negedge clk);
      in_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
